// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI parameter register bank: command field
// layout, FSM state encoding, default bank size and an index range helper.
package spi_reg_pkg;

    localparam int CMD_RD_BIT       = 7;
    localparam int IDX_FIELD_W      = 7;
    localparam int DEFAULT_NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when a register index addresses a real register.
    function automatic logic in_range(input int idx, input int num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/spi_reg_array.sv
// Parameter storage: NUM_REGS x BYTE_W, one synchronous write port, one
// combinational read port for the SPI TX path and one registered read port
// for the synth engine. The engine port samples the array on the same edge
// a write lands, so it returns the pre-write value (read-before-write).
module spi_reg_array
    import spi_reg_pkg::*;
#(
    parameter int BYTE_W   = 8,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  spi_rd_idx,
    output logic [BYTE_W-1:0] spi_rd_data,
    input  logic [IDX_W-1:0]  eng_rd_addr,
    output logic [BYTE_W-1:0] eng_rd_data
);

    logic [BYTE_W-1:0] mem [NUM_REGS];

    // Storage: cleared on reset, written by committed SPI frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign spi_rd_data = mem[spi_rd_idx];

    // Engine read port: one-cycle latency, out-of-range addresses read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_rd_data <= '0;
        end else if (in_range(int'(eng_rd_addr), NUM_REGS)) begin
            eng_rd_data <= mem[eng_rd_addr];
        end else begin
            eng_rd_data <= '0;
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Command decoder and parameter register bank behind the SPI slave.
// Frame = address byte (bit 7 read/write, bits 6:0 index) + data byte.
// Build option: define SPI_REG_READBACK_EN to return register contents on
// read commands; otherwise the TX byte is always 0x00 but the TX handshake
// still runs so the SPI slave never stalls.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int BYTE_W   = 8,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [BYTE_W-1:0] spi_address_rx,
    input  logic              spi_address_rx_valid,
    input  logic [BYTE_W-1:0] spi_data_byte_rx,
    input  logic              spi_data_byte_rx_valid,
    input  logic              spi_dreq,
    output logic [BYTE_W-1:0] spi_data_to_send,
    output logic              spi_data_written,
    input  logic [IDX_W-1:0]  eng_rd_addr,
    output logic [BYTE_W-1:0] eng_rd_data,
    output logic              param_wr_stb,
    output logic [IDX_W-1:0]  param_wr_addr,
    output logic [BYTE_W-1:0] param_wr_data
);

    // TX handshake: spi_dreq is a level request from the SPI slave. The
    // first cycle it is seen high while ack_armed is set, spi_data_written
    // pulses for one cycle on the next edge together with spi_data_to_send.
    // The request is only re-armed once spi_dreq has been seen low, so a
    // request held high yields exactly one pulse.

    logic                   addr_valid_q;
    logic                   data_valid_q;
    logic                   addr_rise;
    logic                   data_rise;
    state_t                 state;       // FSM observation point for checkers
    state_t                 state_next;
    logic                   cmd_rd;
    logic                   cmd_rd_next;
    logic [IDX_FIELD_W-1:0] idx_q;
    logic [IDX_FIELD_W-1:0] idx_next;
    logic                   commit;
    logic                   ack_armed;
    logic [IDX_FIELD_W-1:0] tx_idx;
    logic [BYTE_W-1:0]      spi_rd_data;
    logic [BYTE_W-1:0]      tx_byte;

    // Previous-cycle copies of the valid levels. They track the inputs even
    // during reset so a valid still high at release is not seen as a new edge.
    always_ff @(posedge sys_clk) begin
        addr_valid_q <= spi_address_rx_valid;
        data_valid_q <= spi_data_byte_rx_valid;
    end

    assign addr_rise = spi_address_rx_valid & ~addr_valid_q;
    assign data_rise = spi_data_byte_rx_valid & ~data_valid_q;

    // FSM state and latched command fields.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= IDLE;
            cmd_rd <= 1'b0;
            idx_q  <= '0;
        end else begin
            state  <= state_next;
            cmd_rd <= cmd_rd_next;
            idx_q  <= idx_next;
        end
    end

    // Next state: CS deassert (address valid low) aborts any frame.
    always_comb begin
        state_next  = state;
        cmd_rd_next = cmd_rd;
        idx_next    = idx_q;
        commit      = 1'b0;
        if (!spi_address_rx_valid) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (addr_rise) begin
                        state_next  = ADDR;
                        cmd_rd_next = spi_address_rx[CMD_RD_BIT];
                        idx_next    = spi_address_rx[IDX_FIELD_W-1:0];
                    end
                end
                ADDR: begin
                    if (data_rise) begin
                        state_next = DONE;
                        commit     = !cmd_rd && in_range(int'(idx_q), NUM_REGS);
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Write notification to the engine; addr/data hold until the next commit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            param_wr_stb  <= 1'b0;
            param_wr_addr <= '0;
            param_wr_data <= '0;
        end else begin
            param_wr_stb <= commit;
            if (commit) begin
                param_wr_addr <= idx_q[IDX_W-1:0];
                param_wr_data <= spi_data_byte_rx;
            end
        end
    end

    spi_reg_array #(
        .BYTE_W   (BYTE_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_array (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .wr_en       (commit),
        .wr_idx      (idx_q[IDX_W-1:0]),
        .wr_data     (spi_data_byte_rx),
        .spi_rd_idx  (tx_idx[IDX_W-1:0]),
        .spi_rd_data (spi_rd_data),
        .eng_rd_addr (eng_rd_addr),
        .eng_rd_data (eng_rd_data)
    );

    // The TX byte is indexed straight from the address byte: dreq can rise in
    // the same cycle as address valid, before the FSM has left IDLE.
    assign tx_idx = spi_address_rx[IDX_FIELD_W-1:0];

`ifdef SPI_REG_READBACK_EN
    // TX byte select: register contents only for an in-range read command.
    always_comb begin
        tx_byte = '0;
        if (spi_address_rx_valid && spi_address_rx[CMD_RD_BIT] &&
            in_range(int'(tx_idx), NUM_REGS) &&
            (state == ADDR || (state == IDLE && addr_rise))) begin
            tx_byte = spi_rd_data;
        end
    end
`else
    logic unused_rd_data;
    assign unused_rd_data = ^spi_rd_data;
    assign tx_byte        = '0;
`endif

    // TX response: one pulse per request, re-armed when dreq drops.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack_armed        <= 1'b1;
            spi_data_written <= 1'b0;
            spi_data_to_send <= '0;
        end else begin
            spi_data_written <= 1'b0;
            if (spi_dreq && ack_armed) begin
                spi_data_written <= 1'b1;
                ack_armed        <= 1'b0;
                spi_data_to_send <= tx_byte;
            end else if (!spi_dreq) begin
                ack_armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank. Reference model: a plain array of
// register values updated per completed frame. Honours SPI_REG_READBACK_EN.
module tb_spi_reg_bank;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] spi_address_rx;
    logic       spi_address_rx_valid;
    logic [7:0] spi_data_byte_rx;
    logic       spi_data_byte_rx_valid;
    logic       spi_dreq;
    logic [7:0] spi_data_to_send;
    logic       spi_data_written;
    logic [4:0] eng_rd_addr;
    logic [7:0] eng_rd_data;
    logic       param_wr_stb;
    logic [4:0] param_wr_addr;
    logic [7:0] param_wr_data;

    int total = 0;
    int bad   = 0;
    logic [7:0] model [32];

    spi_reg_bank dut (
        .sys_clk                (sys_clk),
        .sys_rst                (sys_rst),
        .spi_address_rx         (spi_address_rx),
        .spi_address_rx_valid   (spi_address_rx_valid),
        .spi_data_byte_rx       (spi_data_byte_rx),
        .spi_data_byte_rx_valid (spi_data_byte_rx_valid),
        .spi_dreq               (spi_dreq),
        .spi_data_to_send       (spi_data_to_send),
        .spi_data_written       (spi_data_written),
        .eng_rd_addr            (eng_rd_addr),
        .eng_rd_data            (eng_rd_data),
        .param_wr_stb           (param_wr_stb),
        .param_wr_addr          (param_wr_addr),
        .param_wr_data          (param_wr_data)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    // Expected TX byte for an address byte given the current model.
    function automatic logic [7:0] exp_tx(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
`ifdef SPI_REG_READBACK_EN
        if (a[7] && a[6:0] < 7'd32) r = model[a[4:0]];
`endif
        return r;
    endfunction

    // Sweep the engine port over every register and compare with the model.
    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            eng_rd_addr = i[4:0];
            @(negedge sys_clk);
            total++;
            if (eng_rd_data !== model[i]) begin
                bad++;
                $display("FAIL %s reg%0d: got %02h want %02h", tag, i, eng_rd_data, model[i]);
            end
        end
    endtask

    // One SPI frame with dreq raised together with address valid.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] d, input bit abort);
        logic [7:0] old_v;
        logic       exp_commit;
        @(negedge sys_clk);
        spi_address_rx       = a;
        spi_address_rx_valid = 1'b1;
        spi_dreq             = 1'b1;
        @(negedge sys_clk);
        total++;
        if (spi_data_written !== 1'b1 || spi_data_to_send !== exp_tx(a)) begin
            bad++;
            $display("FAIL tx_resp a=%02h: written=%b data=%02h want written=1 data=%02h",
                     a, spi_data_written, spi_data_to_send, exp_tx(a));
        end
        spi_dreq = 1'b0;
        @(negedge sys_clk);
        if (abort) begin
            spi_address_rx_valid = 1'b0;
            repeat (2) begin
                @(negedge sys_clk);
                total++;
                if (param_wr_stb !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_stb a=%02h: got %b want 0", a, param_wr_stb);
                end
            end
            return;
        end
        spi_data_byte_rx       = d;
        spi_data_byte_rx_valid = 1'b1;
        eng_rd_addr            = a[4:0];
        old_v                  = model[a[4:0]];
        exp_commit             = !a[7] && (a[6:0] < 7'd32);
        @(negedge sys_clk);
        total++;
        if (param_wr_stb !== exp_commit ||
            (exp_commit && (param_wr_addr !== a[4:0] || param_wr_data !== d))) begin
            bad++;
            $display("FAIL wr_stb a=%02h d=%02h: stb=%b addr=%0d data=%02h want stb=%b",
                     a, d, param_wr_stb, param_wr_addr, param_wr_data, exp_commit);
        end
        total++;
        if (eng_rd_data !== old_v) begin
            bad++;
            $display("FAIL rd_before_wr a=%02h: got %02h want %02h", a, eng_rd_data, old_v);
        end
        if (exp_commit) model[a[4:0]] = d;
        spi_data_byte_rx = 8'h5A;  // later bytes in the frame must be ignored
        @(negedge sys_clk);
        total++;
        if (param_wr_stb !== 1'b0 || eng_rd_data !== model[a[4:0]]) begin
            bad++;
            $display("FAIL post_wr a=%02h: stb=%b eng=%02h want stb=0 eng=%02h",
                     a, param_wr_stb, eng_rd_data, model[a[4:0]]);
        end
        spi_address_rx_valid   = 1'b0;
        spi_data_byte_rx_valid = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst                = 1'b1;
        spi_address_rx         = 8'h00;
        spi_address_rx_valid   = 1'b0;
        spi_data_byte_rx       = 8'h00;
        spi_data_byte_rx_valid = 1'b0;
        spi_dreq               = 1'b0;
        eng_rd_addr            = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        repeat (3) @(negedge sys_clk);
        total++;
        if ({spi_data_to_send, spi_data_written, eng_rd_data, param_wr_stb,
             param_wr_addr, param_wr_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: tx=%02h wr=%b eng=%02h stb=%b addr=%0d data=%02h want all 0",
                     spi_data_to_send, spi_data_written, eng_rd_data, param_wr_stb,
                     param_wr_addr, param_wr_data);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_all_regs("reset_regs");
    endtask

    task automatic test_write_read();
        run_frame(8'h05, 8'hA7, 1'b0);
        run_frame(8'h85, 8'h3C, 1'b0);
        run_frame(8'h1F, 8'hFF, 1'b0);
        run_frame(8'h9F, 8'h00, 1'b0);
    endtask

    task automatic test_out_of_range();
        run_frame(8'h40, 8'h11, 1'b0);
        run_frame(8'h20, 8'h12, 1'b0);
        check_all_regs("oor_regs");
        run_frame(8'hC0, 8'h00, 1'b0);
        run_frame(8'hA0, 8'h00, 1'b0);
    endtask

    task automatic test_abort();
        run_frame(8'h03, 8'h99, 1'b1);
        check_all_regs("abort_regs");
        run_frame(8'h03, 8'h22, 1'b0);
        run_frame(8'h83, 8'h00, 1'b0);
    endtask

    task automatic test_dreq_hold();
        int pulses;
        pulses = 0;
        @(negedge sys_clk);
        spi_dreq = 1'b1;
        @(negedge sys_clk);
        total++;
        if (spi_data_written !== 1'b1 || spi_data_to_send !== 8'h00) begin
            bad++;
            $display("FAIL dreq_first: written=%b data=%02h want 1/00",
                     spi_data_written, spi_data_to_send);
        end
        if (spi_data_written === 1'b1) pulses++;
        repeat (9) begin
            @(negedge sys_clk);
            if (spi_data_written === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL dreq_hold_pulses: got %0d want 1", pulses);
        end
        spi_dreq = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            if (spi_data_written === 1'b1) pulses++;
        end
        spi_dreq = 1'b1;
        repeat (5) begin
            @(negedge sys_clk);
            if (spi_data_written === 1'b1) pulses++;
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL dreq_rearm_pulses: got %0d want 2", pulses);
        end
        spi_dreq = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid_frame();
        int stbs;
        stbs = 0;
        run_frame(8'h02, 8'h55, 1'b0);
        @(negedge sys_clk);
        spi_address_rx       = 8'h02;
        spi_address_rx_valid = 1'b1;
        @(negedge sys_clk);
        spi_data_byte_rx       = 8'h66;
        spi_data_byte_rx_valid = 1'b1;
        sys_rst                = 1'b1;
        eng_rd_addr            = 5'd2;
        @(negedge sys_clk);
        if (param_wr_stb === 1'b1) stbs++;
        total++;
        if ({spi_data_to_send, spi_data_written, eng_rd_data, param_wr_stb,
             param_wr_addr, param_wr_data} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: tx=%02h wr=%b eng=%02h stb=%b addr=%0d data=%02h want all 0",
                     spi_data_to_send, spi_data_written, eng_rd_data, param_wr_stb,
                     param_wr_addr, param_wr_data);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        repeat (4) begin
            @(negedge sys_clk);
            if (param_wr_stb === 1'b1) stbs++;
        end
        total++;
        if (stbs != 0) begin
            bad++;
            $display("FAIL midrst_stb: got %0d strobes want 0", stbs);
        end
        spi_address_rx_valid   = 1'b0;
        spi_data_byte_rx_valid = 1'b0;
        @(negedge sys_clk);
        check_all_regs("midrst_regs");
        run_frame(8'h02, 8'h77, 1'b0);
        run_frame(8'h82, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] d;
        bit         abort;
        for (int n = 0; n < 40; n++) begin
            a[7]   = 1'($urandom_range(0, 1));
            a[6:0] = 7'($urandom_range(0, 40));
            d      = 8'($urandom);
            abort  = ($urandom_range(0, 4) == 0);
            run_frame(a, d, abort);
        end
        check_all_regs("random_regs");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_abort();
        test_dreq_hold();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Command decoder and parameter register bank directly downstream of the SPI slave (`spi_single_clk`). Consumes the latched address and data bytes of each chip-select frame, writes the addressed synth parameter register, and returns register contents to the SPI slave's transmit path via the `spi_dreq` / `spi_data_written` handshake. The synth engine reads parameters through a registered random-access port and is notified of every update by a write strobe.

## Interface
- `BYTE_W`, 8, SPI byte width.
- `NUM_REGS`, 32, parameter register count (≤ 128).
- `IDX_W`, 5, engine address width, $clog2(NUM_REGS).

- `sys_clk` in 1: system clock; single clock domain.
- `sys_rst` in 1: reset, synchronous, active-high.
- `spi_address_rx` in BYTE_W: first frame byte; bit 7 = read (1) / write (0), bits 6:0 = register index.
- `spi_address_rx_valid` in 1: level; high from first byte until CS deassert.
- `spi_data_byte_rx` in BYTE_W: second frame byte (write payload).
- `spi_data_byte_rx_valid` in 1: level; high from second byte until CS deassert.
- `spi_dreq` in 1: SPI slave requests next TX byte.
- `spi_data_to_send` out BYTE_W: TX byte presented to the SPI slave.
- `spi_data_written` out 1: one-cycle pulse; loads `spi_data_to_send`.
- `eng_rd_addr` in IDX_W: engine read address.
- `eng_rd_data` out BYTE_W: engine read data, 1-cycle latency.
- `param_wr_stb` out 1: one-cycle pulse per committed write.
- `param_wr_addr` out IDX_W: index of committed write.
- `param_wr_data` out BYTE_W: value of committed write.

## Operation
- Reset: all registers 0x00; all outputs 0; FSM to IDLE; `ack_armed` = 1.
- Rising edges of both `_valid` inputs detected internally (previous-cycle flops); the inputs are levels.
- FSM states: IDLE, ADDR, DONE.
  - IDLE → ADDR on rising `spi_address_rx_valid`; latch cmd (bit 7) and index (bits 6:0).
  - ADDR → DONE on rising `spi_data_byte_rx_valid`; on write cmd with index < NUM_REGS, commit: reg[idx] ← data, pulse `param_wr_stb` with addr/data.
  - Index ≥ NUM_REGS: write discarded, no strobe.
  - Read cmd: data byte ignored, no write.
  - Any state → IDLE when `spi_address_rx_valid` is low (CS deassert mid-frame aborts the frame; partial frame writes nothing).
  - Further bytes in DONE: ignored.
- TX response: when `spi_dreq` = 1 and `ack_armed` = 1, next cycle pulse `spi_data_written` for exactly one cycle, clear `ack_armed`; rearm when `spi_dreq` observed low.
  - Data sent: in ADDR with read cmd and in-range index → reg[idx]; otherwise 0x00.
- Engine port: `eng_rd_data` ← reg[eng_rd_addr] each cycle; address ≥ NUM_REGS returns 0x00.
- Same-cycle SPI commit and engine read of same index: engine gets the old value (read-before-write); new value visible on the following read.

## Timing
- Address latch: 1 cycle after rising `spi_address_rx_valid`.
- Write commit: `param_wr_stb` and reg update 1 cycle after rising `spi_data_byte_rx_valid`.
- `spi_data_written`: 1 cycle after `spi_dreq` first seen high. Address valid and dreq rise in the same cycle, so the TX byte must reflect the address decoded that cycle. Data is combinationally indexed from `spi_address_rx` and registered with the pulse.
- `spi_data_to_send` holds its value until the next pulse.
- Reset asserted mid-frame: the frame is discarded; after reset release, the FSM waits for a fresh rising `spi_address_rx_valid`.

## Configuration
- `SPI_REG_READBACK_EN` defined: read commands return reg[idx] as above.
- Undefined: read commands are treated as no-ops; `spi_data_to_send` is constant 0x00; `spi_data_written` handshake is still generated, so the SPI slave never stalls. Engine port is unaffected.

## Structure
- Package `spi_reg_pkg`: `CMD_RD_BIT` = 7, `IDX_FIELD_W` = 7, FSM state enum (IDLE/ADDR/DONE), default `NUM_REGS`.
- One sub-module `spi_reg_array`: NUM_REGS×BYTE_W storage; one synchronous write port; one combinational SPI read port; one registered engine read port. Maps to LUT/FF or EBR.

## Test plan
- Write frame addr 0x05, data 0xA7 → `param_wr_stb` one cycle with addr 5 / data 0xA7; engine read of 5 next cycle returns 0xA7.
- Read frame addr 0x85 after the above → `spi_data_written` pulse 1 cycle after `spi_dreq`, `spi_data_to_send` = 0xA7. Without the macro → 0x00.
- Write addr 0x40 (index 64 ≥ 32), data 0x11 → no strobe; all registers unchanged; read 0xC0 returns 0x00.
- CS deassert after address byte 0x03 only → no write; next full frame 0x03/0x22 commits normally.
- `spi_dreq` held high 10 cycles → exactly one `spi_data_written` pulse; drop and reassert → second pulse.
- `sys_rst` pulsed mid-frame after writing reg 2 = 0x55 → reg 2 reads 0x00; all outputs 0; `param_wr_stb` never fires for the aborted frame.
